// File: rtl/multicycle_control_fsm_pkg.sv
// Shared encodings for the multicycle MIPS control unit.
// Holds opcodes, functs, state codes, datapath mux selects and trap causes.
package multicycle_control_fsm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_TRAP   = 3'd6
    } state_e;

    typedef enum logic [3:0] {
        CL_ADD, CL_ADDU, CL_SLT, CL_JR, CL_ADDI, CL_ADDIU,
        CL_BEQ, CL_BNE, CL_LW, CL_SW, CL_J, CL_JAL
    } class_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_JR   = 6'b001000;

    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_ADDU = 3'd1;
    localparam logic [2:0] ALU_SUB  = 3'd2;
    localparam logic [2:0] ALU_SLT  = 3'd3;

    localparam logic [1:0] PC_SRC_PC4  = 2'd0;
    localparam logic [1:0] PC_SRC_BR   = 2'd1;
    localparam logic [1:0] PC_SRC_JUMP = 2'd2;
    localparam logic [1:0] PC_SRC_RS   = 2'd3;

    localparam logic [1:0] REG_DST_RT = 2'd0;
    localparam logic [1:0] REG_DST_RD = 2'd1;
    localparam logic [1:0] REG_DST_RA = 2'd2;

    localparam logic [1:0] M2R_ALU = 2'd0;
    localparam logic [1:0] M2R_MEM = 2'd1;
    localparam logic [1:0] M2R_PC  = 2'd2;

    localparam logic [1:0] ALUB_RT  = 2'd0;
    localparam logic [1:0] ALUB_4   = 2'd1;
    localparam logic [1:0] ALUB_IMM = 2'd2;
    localparam logic [1:0] ALUB_BR  = 2'd3;

    localparam logic [1:0] CAUSE_NONE    = 2'd0;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
    localparam logic [1:0] CAUSE_BUS     = 2'd2;

endpackage

// File: rtl/multicycle_control_fsm_op_classify.sv
// Combinational instruction classifier: opcode/funct -> class plus illegal flag.
// Zero latency; jal is rejected when SUPPORT_JAL is 0.
module mips_op_classify
    import multicycle_control_fsm_pkg::*;
#(
    parameter bit SUPPORT_JAL = 1'b1
) (
    input  logic [31:0] i_instr,
    output logic [3:0]  o_cls,
    output logic        o_illegal
);

    logic [5:0] w_op;
    logic [5:0] w_fn;
    class_e     w_cls;
    logic       w_illegal;

    assign w_op = i_instr[31:26];
    assign w_fn = i_instr[5:0];

    always_comb begin
        w_cls     = CL_ADD;
        w_illegal = 1'b1;
        case (w_op)
            OP_RTYPE: begin
                case (w_fn)
                    FN_ADD:  begin w_cls = CL_ADD;  w_illegal = 1'b0; end
                    FN_ADDU: begin w_cls = CL_ADDU; w_illegal = 1'b0; end
                    FN_SLT:  begin w_cls = CL_SLT;  w_illegal = 1'b0; end
                    FN_JR:   begin w_cls = CL_JR;   w_illegal = 1'b0; end
                    default: ;
                endcase
            end
            OP_ADDI:  begin w_cls = CL_ADDI;  w_illegal = 1'b0; end
            OP_ADDIU: begin w_cls = CL_ADDIU; w_illegal = 1'b0; end
            OP_BEQ:   begin w_cls = CL_BEQ;   w_illegal = 1'b0; end
            OP_BNE:   begin w_cls = CL_BNE;   w_illegal = 1'b0; end
            OP_LW:    begin w_cls = CL_LW;    w_illegal = 1'b0; end
            OP_SW:    begin w_cls = CL_SW;    w_illegal = 1'b0; end
            OP_J:     begin w_cls = CL_J;     w_illegal = 1'b0; end
            OP_JAL: begin
                w_cls     = CL_JAL;
                w_illegal = !SUPPORT_JAL;
            end
            default: ;
        endcase
    end

    assign o_cls     = w_cls;
    assign o_illegal = w_illegal;

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle MIPS control: FETCH/DECODE/EXEC/MEM/WB sequencing, memory wait with timeout trap.
// Memory ops stall on mem_ready; a sticky trap holds all controls low until reset.
module multicycle_control_fsm
    import multicycle_control_fsm_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32,
    parameter bit SUPPORT_JAL = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      instr,
    input  logic             mem_ready,
    output logic             ir_load,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             mem_req,
    output logic             mem_we,
    output logic             iord,
    output logic             reg_we,
    output logic [1:0]       reg_dst,
    output logic [1:0]       mem_to_reg,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic             ext_signed,
    output logic [2:0]       alu_op,
    output logic             branch,
    output logic             inv_zero,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [CNT_W-1:0] retired,
    output logic [2:0]       state
);

    localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    state_e            r_state;
    logic [WAIT_W-1:0] r_wait;
    logic [CNT_W-1:0]  r_retired;
    logic              r_trap;
    logic [1:0]        r_cause;

    state_e     w_next;
    logic [1:0] w_cause;
    logic       w_wait_inc;
    logic       w_retire;
    logic [3:0] w_cls_raw;
    class_e     w_cls;
    logic       w_illegal;
    logic       w_rtype;

    mips_op_classify #(.SUPPORT_JAL(SUPPORT_JAL)) u_classify (
        .i_instr   (instr),
        .o_cls     (w_cls_raw),
        .o_illegal (w_illegal)
    );

    assign w_cls   = class_e'(w_cls_raw);
    assign w_rtype = (w_cls == CL_ADD) || (w_cls == CL_ADDU) || (w_cls == CL_SLT);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_wait    <= '0;
            r_retired <= '0;
            r_trap    <= 1'b0;
            r_cause   <= CAUSE_NONE;
        end else begin
            r_state <= w_next;
            if (w_next != r_state) begin
                r_wait <= '0;
            end else if (w_wait_inc) begin
                r_wait <= r_wait + WAIT_W'(1);
            end
            if (w_retire) begin
                r_retired <= r_retired + CNT_W'(1);
            end
            if ((w_next == ST_TRAP) && (r_state != ST_TRAP)) begin
                r_trap  <= 1'b1;
                r_cause <= w_cause;
            end
        end
    end

    always_comb begin
        w_next     = r_state;
        w_cause    = CAUSE_NONE;
        w_wait_inc = 1'b0;
        ir_load    = 1'b0;
        pc_write   = 1'b0;
        pc_src     = PC_SRC_PC4;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        reg_we     = 1'b0;
        reg_dst    = REG_DST_RT;
        mem_to_reg = M2R_ALU;
        alu_src_a  = 1'b0;
        alu_src_b  = ALUB_RT;
        ext_signed = 1'b0;
        alu_op     = ALU_ADD;
        branch     = 1'b0;
        inv_zero   = 1'b0;
        case (r_state)
            ST_IDLE: w_next = ST_FETCH;
            ST_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_load   = 1'b1;
                    pc_write  = 1'b1;
                    alu_src_b = ALUB_4;
                    w_next    = ST_DECODE;
                end else if (r_wait == WAIT_LAST) begin
                    w_next  = ST_TRAP;
                    w_cause = CAUSE_BUS;
                end else begin
                    w_wait_inc = 1'b1;
                end
            end
            ST_DECODE: begin
                // Branch target is precomputed here while the opcode resolves.
                alu_src_b = ALUB_BR;
                if (w_illegal) begin
                    w_next  = ST_TRAP;
                    w_cause = CAUSE_ILLEGAL;
                end else begin
                    case (w_cls)
                        CL_J: begin
                            pc_write = 1'b1;
                            pc_src   = PC_SRC_JUMP;
                            w_next   = ST_FETCH;
                        end
                        CL_JAL: begin
                            pc_write   = 1'b1;
                            pc_src     = PC_SRC_JUMP;
                            reg_we     = 1'b1;
                            reg_dst    = REG_DST_RA;
                            mem_to_reg = M2R_PC;
                            w_next     = ST_FETCH;
                        end
                        CL_JR: begin
                            pc_write = 1'b1;
                            pc_src   = PC_SRC_RS;
                            w_next   = ST_FETCH;
                        end
                        default: w_next = ST_EXEC;
                    endcase
                end
            end
            ST_EXEC: begin
                alu_src_a = 1'b1;
                case (w_cls)
                    CL_ADD:   begin alu_op = ALU_ADD;  w_next = ST_WB; end
                    CL_ADDU:  begin alu_op = ALU_ADDU; w_next = ST_WB; end
                    CL_SLT:   begin alu_op = ALU_SLT;  w_next = ST_WB; end
                    CL_ADDI, CL_ADDIU: begin
                        alu_src_b  = ALUB_IMM;
                        ext_signed = 1'b1;
                        alu_op     = (w_cls == CL_ADDI) ? ALU_ADD : ALU_ADDU;
                        w_next     = ST_WB;
                    end
                    CL_LW, CL_SW: begin
                        alu_src_b  = ALUB_IMM;
                        ext_signed = 1'b1;
                        alu_op     = ALU_ADDU;
                        w_next     = ST_MEM;
                    end
                    CL_BEQ, CL_BNE: begin
                        alu_op   = ALU_SUB;
                        branch   = 1'b1;
                        pc_src   = PC_SRC_BR;
                        inv_zero = (w_cls == CL_BNE);
                        w_next   = ST_FETCH;
                    end
                    default: begin
                        // Only reachable if the IR changed after DECODE.
                        w_next  = ST_TRAP;
                        w_cause = CAUSE_ILLEGAL;
                    end
                endcase
            end
            ST_MEM: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                mem_we  = (w_cls == CL_SW);
                if (mem_ready) begin
                    w_next = (w_cls == CL_SW) ? ST_FETCH : ST_WB;
                end else if (r_wait == WAIT_LAST) begin
                    w_next  = ST_TRAP;
                    w_cause = CAUSE_BUS;
                end else begin
                    w_wait_inc = 1'b1;
                end
            end
            ST_WB: begin
                reg_we     = 1'b1;
                reg_dst    = w_rtype ? REG_DST_RD : REG_DST_RT;
                mem_to_reg = (w_cls == CL_LW) ? M2R_MEM : M2R_ALU;
                w_next     = ST_FETCH;
            end
            ST_TRAP: w_next = ST_TRAP;
            default: w_next = ST_IDLE;
        endcase
    end

    assign w_retire = (w_next == ST_FETCH) &&
                      ((r_state == ST_DECODE) || (r_state == ST_EXEC) ||
                       (r_state == ST_MEM) || (r_state == ST_WB));

    assign trap       = r_trap;
    assign trap_cause = r_cause;
    assign retired    = r_retired;
    assign state      = r_state;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: one jal-capable unit with a 4-bit
// retire counter and a jal-less twin driven by the same stimulus.
module tb_multicycle_control_fsm;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr;
    logic        mem_ready;

    logic       ir_load_a, pc_write_a, mem_req_a, mem_we_a, iord_a, reg_we_a;
    logic       alu_src_a_a, ext_signed_a, branch_a, inv_zero_a, trap_a;
    logic [1:0] pc_src_a, reg_dst_a, mem_to_reg_a, alu_src_b_a, trap_cause_a;
    logic [2:0] alu_op_a, state_a;
    logic [3:0] retired_a;

    logic       ir_load_b, pc_write_b, mem_req_b, mem_we_b, iord_b, reg_we_b;
    logic       alu_src_a_b, ext_signed_b, branch_b, inv_zero_b, trap_b;
    logic [1:0] pc_src_b, reg_dst_b, mem_to_reg_b, alu_src_b_b, trap_cause_b;
    logic [2:0] alu_op_b, state_b;
    logic [3:0] retired_b;

    logic [20:0] ctl_a;
    assign ctl_a = {ir_load_a, pc_write_a, pc_src_a, mem_req_a, mem_we_a, iord_a,
                    reg_we_a, reg_dst_a, mem_to_reg_a, alu_src_a_a, alu_src_b_a,
                    ext_signed_a, alu_op_a, branch_a, inv_zero_a};

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    multicycle_control_fsm #(.MEM_TIMEOUT(15), .CNT_W(4), .SUPPORT_JAL(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .mem_ready(mem_ready),
        .ir_load(ir_load_a), .pc_write(pc_write_a), .pc_src(pc_src_a),
        .mem_req(mem_req_a), .mem_we(mem_we_a), .iord(iord_a), .reg_we(reg_we_a),
        .reg_dst(reg_dst_a), .mem_to_reg(mem_to_reg_a), .alu_src_a(alu_src_a_a),
        .alu_src_b(alu_src_b_a), .ext_signed(ext_signed_a), .alu_op(alu_op_a),
        .branch(branch_a), .inv_zero(inv_zero_a), .trap(trap_a),
        .trap_cause(trap_cause_a), .retired(retired_a), .state(state_a)
    );

    multicycle_control_fsm #(.MEM_TIMEOUT(15), .CNT_W(4), .SUPPORT_JAL(1'b0)) u_dut_nojal (
        .clk(clk), .rst_n(rst_n), .instr(instr), .mem_ready(mem_ready),
        .ir_load(ir_load_b), .pc_write(pc_write_b), .pc_src(pc_src_b),
        .mem_req(mem_req_b), .mem_we(mem_we_b), .iord(iord_b), .reg_we(reg_we_b),
        .reg_dst(reg_dst_b), .mem_to_reg(mem_to_reg_b), .alu_src_a(alu_src_a_b),
        .alu_src_b(alu_src_b_b), .ext_signed(ext_signed_b), .alu_op(alu_op_b),
        .branch(branch_b), .inv_zero(inv_zero_b), .trap(trap_b),
        .trap_cause(trap_cause_b), .retired(retired_b), .state(state_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one edge and settle past it; inputs change only here, between edges.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst_n     = 1'b0;
        instr     = 32'h0;
        mem_ready = 1'b0;
        tick();
        tick();
        check("rst_state", 32'(state_a), 32'd0);
        check("rst_retired", 32'(retired_a), 32'd0);
        check("rst_trap", 32'({trap_a, trap_cause_a}), 32'd0);
        check("rst_ctl", 32'(ctl_a), 32'd0);

        // addu $3,$1,$2 with zero-wait memory: 1,2,3,5,1
        rst_n = 1'b1; mem_ready = 1'b1; instr = 32'h00221821;
        tick(); #1;
        check("addu_fetch", 32'({state_a, ir_load_a, pc_write_a, mem_req_a, iord_a, alu_src_b_a}), {26'd0, 3'd1, 1'b1, 1'b1, 1'b1, 1'b0, 2'd1});
        tick();
        check("addu_decode", 32'({state_a, alu_src_a_a, alu_src_b_a, alu_op_a}), {23'd0, 3'd2, 1'b0, 2'd3, 3'd0});
        tick();
        check("addu_exec", 32'({state_a, alu_src_a_a, alu_src_b_a, alu_op_a}), {23'd0, 3'd3, 1'b1, 2'd0, 3'd1});
        tick();
        check("addu_wb", 32'({state_a, reg_we_a, reg_dst_a, mem_to_reg_a}), {24'd0, 3'd5, 1'b1, 2'd1, 2'd0});
        tick();
        check("addu_retire", 32'({state_a, retired_a}), {25'd0, 3'd1, 4'd1});

        // lw with three wait cycles in MEM
        instr = 32'h8C080004;
        tick();
        tick();
        check("lw_exec", 32'({state_a, alu_src_a_a, alu_src_b_a, ext_signed_a, alu_op_a}), {22'd0, 3'd3, 1'b1, 2'd2, 1'b1, 3'd1});
        mem_ready = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin
                mem_ready = 1'b1;
                #1;
            end
            check($sformatf("lw_mem%0d", i), 32'({state_a, mem_req_a, iord_a, mem_we_a}), {26'd0, 3'd4, 3'b110});
            if (i < 3) tick();
        end
        tick();
        check("lw_wb", 32'({state_a, reg_we_a, reg_dst_a, mem_to_reg_a}), {24'd0, 3'd5, 1'b1, 2'd0, 2'd1});
        tick();
        check("lw_retire", 32'({state_a, retired_a}), {25'd0, 3'd1, 4'd2});

        // bne: 3 cycles, branch controls in EXEC
        instr = 32'h14220003;
        tick();
        tick();
        check("bne_exec", 32'({state_a, branch_a, inv_zero_a, pc_src_a, alu_op_a, alu_src_b_a}), {21'd0, 3'd3, 1'b1, 1'b1, 2'd1, 3'd2, 2'd0});
        tick();
        check("bne_retire", 32'({state_a, retired_a}), {25'd0, 3'd1, 4'd3});

        // jal: legal on u_dut, illegal on the jal-less twin
        instr = 32'h0C000010;
        tick();
        check("jal_decode", 32'({state_a, pc_write_a, pc_src_a, reg_we_a, reg_dst_a, mem_to_reg_a}), {22'd0, 3'd2, 1'b1, 2'd2, 1'b1, 2'd2, 2'd2});
        tick();
        check("jal_retire", 32'({state_a, retired_a}), {25'd0, 3'd1, 4'd4});
        check("nojal_trap", 32'({state_b, trap_b, trap_cause_b, retired_b}), {22'd0, 3'd6, 1'b1, 2'd1, 4'd3});

        // illegal opcode traps without retiring
        instr = 32'hFC000000;
        tick();
        tick();
        check("ill_trap", 32'({state_a, trap_a, trap_cause_a, retired_a}), {22'd0, 3'd6, 1'b1, 2'd1, 4'd4});
        check("ill_ctl", 32'(ctl_a), 32'd0);
        tick();
        check("ill_hold", 32'({state_a, trap_a, trap_cause_a}), {26'd0, 3'd6, 1'b1, 2'd1});

        // one-edge reset from TRAP
        rst_n = 1'b0;
        tick();
        check("rst2_state", 32'({state_a, state_b}), 32'd0);
        check("rst2_flags", 32'({trap_a, trap_cause_a, retired_a}), 32'd0);
        check("rst2_ctl", 32'(ctl_a), 32'd0);

        // FETCH timeout: 15 cycles without ready, then bus trap
        rst_n = 1'b1; mem_ready = 1'b0;
        tick();
        for (int i = 0; i < 15; i++) begin
            check($sformatf("to_wait%0d", i), 32'({state_a, mem_req_a, ir_load_a}), {27'd0, 3'd1, 1'b1, 1'b0});
            tick();
        end
        check("to_trap", 32'({state_a, trap_a, trap_cause_a, retired_a}), {22'd0, 3'd6, 1'b1, 2'd2, 4'd0});

        // ready in the 15th wait cycle wins over the timeout
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 14; i++) tick();
        mem_ready = 1'b1;
        #1;
        check("rw_irload", 32'({state_a, ir_load_a}), {28'd0, 3'd1, 1'b1});
        tick();
        check("rw_decode", 32'({state_a, trap_a}), {28'd0, 3'd2, 1'b0});

        // retire-counter wrap with back-to-back j (2 cycles each)
        instr = 32'h08000000;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 15; i++) begin
            tick();
            if (i == 0) check("j_decode", 32'({state_a, pc_write_a, pc_src_a, reg_we_a}), {26'd0, 3'd2, 1'b1, 2'd2, 1'b0});
            tick();
        end
        check("wrap_max", 32'({state_a, retired_a}), {25'd0, 3'd1, 4'd15});
        tick();
        tick();
        check("wrap_zero", 32'({state_a, retired_a}), {25'd0, 3'd1, 4'd0});

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
